// File: rtl/bcd_sched_pkg.sv
// Shared constants, FSM state encoding and digit bundle for the BCD conversion scheduler.
package bcd_sched_pkg;
  localparam int             BIN_W   = 12;
  localparam int             DIG_W   = 4;
  localparam logic [BIN_W-1:0] MAX_DEC = 12'd999;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [DIG_W-1:0] d2;
    logic [DIG_W-1:0] d1;
    logic [DIG_W-1:0] d0;
  } bcd3_t;
endpackage

// File: rtl/bcd_conv_sched_if.sv
// Requester and converter bus of the scheduler; slave = scheduler side, master = requesters/converter.
interface bcd_conv_sched_if
  import bcd_sched_pkg::*;
#(parameter int N_REQ = 4);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*BIN_W-1:0] bin_in;
  logic [N_REQ-1:0]       ack;
  logic [DIG_W-1:0]       res_dig2, res_dig1, res_dig0;
  logic                   res_ovf, res_err, busy;
  logic                   conv_start;
  logic [BIN_W-1:0]       conv_bin;
  logic                   conv_done;
  logic [DIG_W-1:0]       conv_dig2, conv_dig1, conv_dig0;

  modport slave (
    input  req, bin_in, conv_done, conv_dig2, conv_dig1, conv_dig0,
    output ack, res_dig2, res_dig1, res_dig0, res_ovf, res_err, busy, conv_start, conv_bin
  );
  modport master (
    output req, bin_in, conv_done, conv_dig2, conv_dig1, conv_dig0,
    input  ack, res_dig2, res_dig1, res_dig0, res_ovf, res_err, busy, conv_start, conv_bin
  );
endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin pick: first set req bit after 'last', wrapping modulo N_REQ.
module rr_arb #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  int p;

  // Scan farthest-first so the nearest candidate after 'last' overwrites the rest.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    p     = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      p = (int'(last) + k) % N_REQ;
      if (req[p]) begin
        valid = 1'b1;
        idx   = IDX_W'(p);
      end
    end
  end
endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one binary-to-BCD converter among N_REQ requesters.
// Optional converter watchdog enabled by defining CONV_TIMEOUT_EN.
module bcd_conv_sched
  import bcd_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input logic              clk,
  input logic              rst,
  bcd_conv_sched_if.slave  bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state, state_d;
  logic [IDX_W-1:0] last, idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic [BIN_W-1:0] pick_val, val;
  logic             pick_ovf;
  bcd3_t            res;
  logic             ovf, err;
  logic             timeout;

  rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req   (bus.req),
    .last  (last),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign pick_val = bus.bin_in[pick_idx*BIN_W +: BIN_W];
  assign pick_ovf = pick_val > MAX_DEC;

`ifdef CONV_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TO_W-1:0] wait_cnt;

  // Held at zero outside WAIT, so each WAIT visit starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + TO_W'(1);
  end
  assign timeout = (state == WAIT) && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pick_vld) state_d = pick_ovf ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.conv_done || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results load on the transition into RESP so they are valid in the ack cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= IDX_W'(N_REQ - 1);
      idx  <= '0;
      val  <= '0;
      res  <= '0;
      ovf  <= 1'b0;
      err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          idx <= pick_idx;
          val <= pick_val;
          if (pick_ovf) begin
            res <= '{d2: 4'd9, d1: 4'd9, d0: 4'd9};
            ovf <= 1'b1;
            err <= 1'b0;
          end
        end
        WAIT: if (bus.conv_done) begin
          res <= '{d2: bus.conv_dig2, d1: bus.conv_dig1, d0: bus.conv_dig0};
          ovf <= 1'b0;
          err <= 1'b0;
        end else if (timeout) begin
          res <= '0;
          ovf <= 1'b0;
          err <= 1'b1;
        end
        RESP: last <= idx;
        default: ;
      endcase
    end
  end

  assign bus.ack        = (state == RESP) ? (N_REQ'(1) << idx) : '0;
  assign bus.conv_start = (state == ISSUE);
  assign bus.conv_bin   = val;
  assign bus.busy       = (state != IDLE);
  assign bus.res_dig2   = res.d2;
  assign bus.res_dig1   = res.d1;
  assign bus.res_dig0   = res.d0;
  assign bus.res_ovf    = ovf;
  assign bus.res_err    = err;
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched with a behavioural converter of programmable latency.
module tb_bcd_conv_sched;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_conv_sched_if #(.N_REQ(N)) bus();
  bcd_conv_sched #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  // Converter model: done pulses conv_lat cycles after the start cycle.
  int          conv_lat = 24;
  bit          mute     = 1'b0;
  bit          stray    = 1'b0;
  int          cnt      = 0;
  int          n_start  = 0;
  logic [11:0] seen_bin = '0;

  always @(negedge clk) begin
    bus.conv_done = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) bus.conv_done = 1'b1;
    end
    if (stray) bus.conv_done = 1'b1;
    if (bus.conv_start === 1'b1) begin
      n_start++;
      seen_bin      = bus.conv_bin;
      bus.conv_dig2 = 4'(bus.conv_bin / 100);
      bus.conv_dig1 = 4'((bus.conv_bin / 10) % 10);
      bus.conv_dig0 = 4'(bus.conv_bin % 10);
      if (!mute) cnt = conv_lat;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(input int bound, output logic [N-1:0] a, output int lat);
    a = '0;
    lat = 0;
    while (lat < bound) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (bus.ack !== '0) begin
        a = bus.ack;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.ack, bus.busy, bus.conv_start} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctl got ack=%b busy=%b start=%b required 0", bus.ack, bus.busy, bus.conv_start);
    end
    n_chk++;
    if ({bus.res_dig2, bus.res_dig1, bus.res_dig0, bus.res_ovf, bus.res_err, bus.conv_bin} !== '0) begin
      n_fail++;
      $display("FAIL reset_res got dig=%h%h%h ovf=%b err=%b bin=%0d required 0",
               bus.res_dig2, bus.res_dig1, bus.res_dig0, bus.res_ovf, bus.res_err, bus.conv_bin);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [N-1:0] a;
    int lat, n0;
    @(negedge clk);
    n0 = n_start;
    conv_lat = 24;
    bus.bin_in[11:0] = 12'd190;
    bus.req = 4'b0001;
    wait_ack(60, a, lat);
    bus.req = '0;
    n_chk++;
    if (a !== 4'b0001 || lat != 26) begin
      n_fail++;
      $display("FAIL single_ack got ack=%b cycle=%0d required 0001 at 26", a, lat);
    end
    n_chk++;
    if ({bus.res_dig2, bus.res_dig1, bus.res_dig0, bus.res_ovf, bus.res_err} !== {12'h190, 2'b00}) begin
      n_fail++;
      $display("FAIL single_res got dig=%h%h%h ovf=%b err=%b required 190 0 0",
               bus.res_dig2, bus.res_dig1, bus.res_dig0, bus.res_ovf, bus.res_err);
    end
    n_chk++;
    if (n_start - n0 != 1 || seen_bin !== 12'd190) begin
      n_fail++;
      $display("FAIL single_start got starts=%0d bin=%0d required 1 190", n_start - n0, seen_bin);
    end
    @(negedge clk);
    n_chk++;
    if (bus.ack !== '0 || bus.res_dig0 !== 4'd0 || bus.res_dig1 !== 4'd9) begin
      n_fail++;
      $display("FAIL single_hold got ack=%b dig=%h%h%h required ack 0, digits held 190",
               bus.ack, bus.res_dig2, bus.res_dig1, bus.res_dig0);
    end
  endtask

  task automatic test_all_four();
    logic [N-1:0] a;
    int lat;
    logic [N-1:0] exp_a [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [11:0]  exp_d [4] = '{12'h005, 12'h042, 12'h999, 12'h000};
    do_reset();
    conv_lat = 4;
    bus.bin_in = {12'd0, 12'd999, 12'd42, 12'd5};
    bus.req = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      wait_ack(40, a, lat);
      bus.req = bus.req & ~a;
      n_chk++;
      if (a !== exp_a[j] || {bus.res_dig2, bus.res_dig1, bus.res_dig0} !== exp_d[j] || bus.res_ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL all4_job%0d got ack=%b dig=%h%h%h ovf=%b required %b %h 0", j, a,
                 bus.res_dig2, bus.res_dig1, bus.res_dig0, bus.res_ovf, exp_a[j], exp_d[j]);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_overflow();
    logic [N-1:0] a;
    int lat, n0;
    logic [11:0] vals [2] = '{12'd1000, 12'd4095};
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      n0 = n_start;
      bus.bin_in[35:24] = vals[j];
      bus.req = 4'b0100;
      wait_ack(10, a, lat);
      bus.req = '0;
      n_chk++;
      if (a !== 4'b0100 || lat != 1 || n_start != n0) begin
        n_fail++;
        $display("FAIL ovf%0d_ack got ack=%b cycle=%0d starts=%0d required 0100 at 1 with 0 starts",
                 vals[j], a, lat, n_start - n0);
      end
      n_chk++;
      if ({bus.res_dig2, bus.res_dig1, bus.res_dig0, bus.res_ovf, bus.res_err} !== {12'h999, 2'b10}) begin
        n_fail++;
        $display("FAIL ovf%0d_res got dig=%h%h%h ovf=%b err=%b required 999 1 0", vals[j],
                 bus.res_dig2, bus.res_dig1, bus.res_dig0, bus.res_ovf, bus.res_err);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    logic [N-1:0] a;
    int lat, acks, busys;
    @(negedge clk);
    conv_lat = 10;
    bus.bin_in[11:0] = 12'd123;
    bus.req = 4'b0001;
    repeat (5) @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstwait_busy got %b required 1", bus.busy);
    end
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    busys = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.ack !== '0) acks++;
      if (bus.busy !== 1'b0) busys++;
    end
    n_chk++;
    if (acks != 0 || busys != 0) begin
      n_fail++;
      $display("FAIL rstwait_idle got acks=%0d busy_cycles=%0d required 0 0", acks, busys);
    end
    n_chk++;
    if ({bus.res_dig2, bus.res_dig1, bus.res_dig0, bus.res_ovf, bus.res_err, bus.conv_bin, bus.conv_start} !== '0) begin
      n_fail++;
      $display("FAIL rstwait_outs got dig=%h%h%h ovf=%b err=%b bin=%0d required 0",
               bus.res_dig2, bus.res_dig1, bus.res_dig0, bus.res_ovf, bus.res_err, bus.conv_bin);
    end
    conv_lat = 3;
    bus.bin_in[23:12] = 12'd7;
    bus.bin_in[47:36] = 12'd250;
    bus.req = 4'b1010;
    wait_ack(20, a, lat);
    bus.req = bus.req & ~a;
    n_chk++;
    if (a !== 4'b0010 || {bus.res_dig2, bus.res_dig1, bus.res_dig0} !== 12'h007) begin
      n_fail++;
      $display("FAIL rstwait_ptr got ack=%b dig=%h%h%h required 0010 007", a, bus.res_dig2, bus.res_dig1, bus.res_dig0);
    end
    wait_ack(20, a, lat);
    bus.req = bus.req & ~a;
    n_chk++;
    if (a !== 4'b1000 || {bus.res_dig2, bus.res_dig1, bus.res_dig0} !== 12'h250) begin
      n_fail++;
      $display("FAIL rstwait_next got ack=%b dig=%h%h%h required 1000 250", a, bus.res_dig2, bus.res_dig1, bus.res_dig0);
    end
    bus.req = '0;
  endtask

  task automatic test_drop_in_wait();
    logic [N-1:0] a;
    int lat, acks, busys;
    @(negedge clk);
    conv_lat = 8;
    bus.bin_in[47:36] = 12'd321;
    bus.req = 4'b1000;
    repeat (3) @(negedge clk);
    bus.req = '0;
    wait_ack(7, a, lat);
    lat = lat + 3;
    n_chk++;
    if (a !== 4'b1000 || lat != 10 || {bus.res_dig2, bus.res_dig1, bus.res_dig0} !== 12'h321) begin
      n_fail++;
      $display("FAIL drop_ack got ack=%b cycle=%0d dig=%h%h%h required 1000 at 10 321",
               a, lat, bus.res_dig2, bus.res_dig1, bus.res_dig0);
    end
    @(negedge clk);
    acks = 0;
    busys = 0;
    repeat (3) begin
      @(posedge clk);
      #1 stray = 1'b1;
      @(posedge clk);
      #1 stray = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (bus.ack !== '0) acks++;
        if (bus.busy !== 1'b0) busys++;
      end
    end
    n_chk++;
    if (acks != 0 || busys != 0 || {bus.res_dig2, bus.res_dig1, bus.res_dig0} !== 12'h321) begin
      n_fail++;
      $display("FAIL stray_done got acks=%0d busy_cycles=%0d dig=%h%h%h required 0 0 321",
               acks, busys, bus.res_dig2, bus.res_dig1, bus.res_dig0);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a;
    int lat;
    logic [N-1:0] exp_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [11:0]  exp_d [5] = '{12'h011, 12'h111, 12'h211, 12'h311, 12'h011};
    do_reset();
    conv_lat = 2;
    bus.bin_in = {12'd311, 12'd211, 12'd111, 12'd11};
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_ack(20, a, lat);
      if (j == 4) bus.req = '0;
      n_chk++;
      if (a !== exp_a[j] || {bus.res_dig2, bus.res_dig1, bus.res_dig0} !== exp_d[j]) begin
        n_fail++;
        $display("FAIL rr_grant%0d got ack=%b dig=%h%h%h required %b %h", j, a,
                 bus.res_dig2, bus.res_dig1, bus.res_dig0, exp_a[j], exp_d[j]);
      end
    end
  endtask

`ifdef CONV_TIMEOUT_EN
  task automatic test_timeout();
    logic [N-1:0] a;
    int lat;
    @(negedge clk);
    mute = 1'b1;
    bus.bin_in[11:0] = 12'd55;
    bus.req = 4'b0001;
    wait_ack(100, a, lat);
    bus.req = '0;
    mute = 1'b0;
    n_chk++;
    if (a !== 4'b0001 || lat != TO + 2) begin
      n_fail++;
      $display("FAIL timeout_ack got ack=%b cycle=%0d required 0001 at %0d", a, lat, TO + 2);
    end
    n_chk++;
    if ({bus.res_dig2, bus.res_dig1, bus.res_dig0, bus.res_ovf, bus.res_err} !== {12'h000, 2'b01}) begin
      n_fail++;
      $display("FAIL timeout_res got dig=%h%h%h ovf=%b err=%b required 000 0 1",
               bus.res_dig2, bus.res_dig1, bus.res_dig0, bus.res_ovf, bus.res_err);
    end
    @(negedge clk);
    conv_lat = 2;
    bus.bin_in[23:12] = 12'd88;
    bus.req = 4'b0010;
    wait_ack(20, a, lat);
    bus.req = '0;
    n_chk++;
    if (a !== 4'b0010 || {bus.res_dig2, bus.res_dig1, bus.res_dig0, bus.res_err} !== {12'h088, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_next got ack=%b dig=%h%h%h err=%b required 0010 088 0",
               a, bus.res_dig2, bus.res_dig1, bus.res_dig0, bus.res_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_overflow();
    test_reset_in_wait();
    test_drop_in_wait();
    test_back_to_back();
`ifdef CONV_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
- Round-robin scheduler that shares one binary-to-BCD (double-dabble) converter among N_REQ requesters. Typical requesters are sensor channels and counters feeding the display path.
- Per job: accepts a 12-bit binary value, sequences the converter with a start/done handshake, and returns three BCD digits plus status to the requester.
- Handles out-of-range values (>999) itself, without occupying the converter.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYC, 64: converter watchdog limit in cycles. Used only with CONV_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester request level; held until ack
- bin_in  in  N_REQ*12  packed binary values; requester i uses bits [12i+11:12i]; must be stable while req[i] is high
- ack  out  N_REQ  one-hot, one-cycle completion pulse
- res_dig2  out  4  hundreds digit
- res_dig1  out  4  tens digit
- res_dig0  out  4  ones digit
- res_ovf  out  1  value exceeded 999; digits saturated to 9,9,9
- res_err  out  1  converter timeout (CONV_TIMEOUT_EN only, else 0)
- busy  out  1  high in every state except IDLE
- conv_start  out  1  one-cycle start pulse to converter
- conv_bin  out  12  operand to converter; held from ISSUE until the job completes
- conv_done  in  1  converter completion pulse
- conv_dig2, conv_dig1, conv_dig0  in  4 each  converter result digits, valid while conv_done is high

Behaviour:
- Reset (synchronous): state=IDLE; last-grant pointer=N_REQ-1, so requester 0 has first priority. Outputs ack, res_*, conv_start, conv_bin and busy are all 0. Reset mid-job abandons the job with no ack; a late conv_done is then ignored.
- States:
  - IDLE: if any req bit is high, grant the first set bit searching from last+1, wrapping modulo N_REQ. Latch idx and bin_in[idx]. If the value is >999, go to RESP with digits 9,9,9 and res_ovf=1. Otherwise go to ISSUE.
  - ISSUE: conv_start=1 for exactly this cycle; conv_bin=latched value. Go to WAIT.
  - WAIT: hold conv_bin. On conv_done, capture conv_dig2..0 into res_dig2..0, clear res_ovf and res_err, and go to RESP.
  - RESP: ack[idx]=1 for this cycle only; last<=idx; go to IDLE.
- Results: res_* are registered and hold their value from the ack cycle until the next ack.
- Latency, normal path: req seen in IDLE at cycle 0 -> conv_start at cycle 1 -> conv_done at cycle k -> ack at cycle k+1.
- Latency, overflow path: req at cycle 0 -> ack at cycle 1.
- Requester rule: req[i] must be low by the cycle after ack[i], i.e. a registered drop. A requester that holds req high afterwards is treated as a new request.
- Committed jobs: once granted, a job completes even if req[idx] falls; ack is still pulsed.
- conv_done arriving outside WAIT is ignored.
- Simultaneous requests: exactly one grant per job. Fairness guarantee: with all requesters active, grants rotate 0,1,2,...,N_REQ-1,0.
- Boundaries: value 999 is converted normally; value 1000 takes the overflow path; value 0 gives 0,0,0.

Optional Feature:
- Macro: CONV_TIMEOUT_EN.
- Defined: a WAIT-cycle counter is cleared on entry to WAIT. If the count reaches TIMEOUT_CYC-1 with no conv_done, go to RESP with digits 0,0,0 and res_err=1. conv_done and timeout in the same cycle: conv_done wins.
- Undefined: no counter; WAIT is unbounded; res_err is tied to 0.

Decomposition:
- Package bcd_sched_pkg holds:
  - constants BIN_W=12, DIG_W=4, MAX_DEC=12'd999;
  - state enum IDLE/ISSUE/WAIT/RESP, 2-bit encoding;
  - typedef bcd3_t as a struct of three 4-bit digits.
- Sub-module rr_arb: combinational round-robin pick. Inputs req and last; outputs a valid flag and idx of width $clog2(N_REQ).

Test Plan:
- Single requester: req[0]=1, bin=190; bench converter with 24-cycle done -> conv_bin=190 and one conv_start pulse; ack[0] at cycle 26; digits 1,9,0; ovf=0; err=0.
- All four requesters asserted at once with values 5, 42, 999, 0 -> acks in order 0,1,2,3; digits 0,0,5 / 0,4,2 / 9,9,9 with ovf=0 / 0,0,0.
- Overflow: req[2]=1, bin=1000 -> no conv_start; ack[2] at cycle 1; digits 9,9,9; ovf=1. Repeat with bin=4095 for the same result.
- Reset in WAIT, then a late conv_done -> no ack; all outputs 0; next req[1] is granted (pointer was reset).
- req[3] dropped during WAIT -> ack[3] still pulses when conversion completes. Stray conv_done pulses in IDLE -> ignored.
- CONV_TIMEOUT_EN defined, converter never answers -> ack after TIMEOUT_CYC WAIT cycles; res_err=1; digits 0,0,0; next requester is then served normally.
